mp_stream_multiplier: RTL and testbench

Parametrised, streaming multi-precision multiplier: accepts two BITS_IN_NUM-bit operands as parallel REGISTER_SIZE-bit block streams, computes the product by block-wise schoolbook accumulation in internal memory, and streams the result out least-significant block first. Successor to the single-operand fixed multiplier:
- both operands are streamed; neither is taken from an init file;
- runtime full-product or low-half (mod 2^BITS_IN_NUM, for Montgomery/modular stages) mode;
- output backpressure;
- self-clearing accumulator with a post-reset CLEAR phase.

---
 rtl/mp_stream_multiplier.sv | 239 +++++++++++++++++++++++
 tb/tb_mp_stream_multiplier.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/mp_stream_multiplier.sv
// mp_stream_multiplier
//
// Streaming multi-precision multiplier. Two BITS_IN_NUM-bit operands arrive
// as parallel streams of REGISTER_SIZE-bit blocks (least-significant block
// first). The product is built by block-wise schoolbook accumulation in an
// internal accumulator of 2K blocks. The result then streams out
// least-significant block first. Each accumulator entry is zeroed as it
// leaves, so the next operation starts from a clean accumulator.
//
// Ports
//   clk_in     : clock, rising edge
//   rst_in     : asynchronous reset, active low
//   a_in/b_in  : operand blocks, one pair per accepted beat
//   valid_in   : beat valid; accepted when valid_in && ready_out
//   mode_in    : 0 = full 2N-bit product, 1 = low N bits (sampled on first beat)
//   ready_out  : high while idle or loading operands
//   data_out   : result block
//   valid_out  : data_out valid
//   last_out   : marks the final result block
//   ready_in   : downstream accept; a block transfers on valid_out && ready_in
`timescale 1ns/1ps
module mp_stream_multiplier #(
  parameter int REGISTER_SIZE = 32,
  parameter int BITS_IN_NUM   = 4096
) (
  input  logic                     clk_in,
  input  logic                     rst_in,
  input  logic [REGISTER_SIZE-1:0] a_in,
  input  logic [REGISTER_SIZE-1:0] b_in,
  input  logic                     valid_in,
  input  logic                     mode_in,
  output logic                     ready_out,
  output logic [REGISTER_SIZE-1:0] data_out,
  output logic                     valid_out,
  output logic                     last_out,
  input  logic                     ready_in
);

  localparam int W  = REGISTER_SIZE;
  localparam int K  = BITS_IN_NUM / REGISTER_SIZE;
  localparam int CW = $clog2(2*K+1);
  localparam int AW = (K > 1) ? $clog2(K) : 1;
  localparam int RW = $clog2(2*K);

  localparam logic [CW-1:0] K_C      = CW'(K);
  localparam logic [CW-1:0] LASTK_C  = CW'(K-1);
  localparam logic [CW-1:0] LAST2K_C = CW'(2*K-1);

  localparam logic [2:0] S_CLEAR   = 3'd0;
  localparam logic [2:0] S_IDLE    = 3'd1;
  localparam logic [2:0] S_LOAD    = 3'd2;
  localparam logic [2:0] S_COMPUTE = 3'd3;
  localparam logic [2:0] S_OUTPUT  = 3'd4;

  logic [2:0]    state_q, state_d;
  logic [CW-1:0] idx_q, idx_d;
  logic [CW-1:0] i_q, i_d;
  logic [CW-1:0] j_q, j_d;
  logic          cp_q, cp_d;
  logic          ca_q, ca_d;
  logic [W-1:0]  hi_q, hi_d;
  logic          mode_q, mode_d;

  logic [W-1:0]  a_mem_q [K];
  logic [W-1:0]  b_mem_q [K];
  logic [W-1:0]  acc_q   [2*K];

  logic          accept;
  logic          xfer;
  logic [W-1:0]  a_j;
  logic [W-1:0]  b_i;
  logic [W-1:0]  hi_in;
  logic          cp_in;
  logic          ca_in;
  logic [2*W-1:0] p_cur;
  logic [W:0]    s1;
  logic [W:0]    s2;
  logic [RW-1:0] acc_idx;
  logic [W-1:0]  acc_rd;
  logic          j_last;
  logic          row_last;
  logic          acc_we;
  logic [RW-1:0] acc_wa;
  logic [W-1:0]  acc_wd;

  // Handshake and output decode, all from registered state so outputs are
  // clean and fall to zero as soon as reset forces CLEAR.
  always_comb begin
    ready_out = (state_q == S_IDLE) || (state_q == S_LOAD);
    valid_out = (state_q == S_OUTPUT);
    last_out  = valid_out && (idx_q == (mode_q ? LASTK_C : LAST2K_C));
    data_out  = valid_out ? acc_q[idx_q[RW-1:0]] : '0;
    accept    = valid_in && ready_out;
    xfer      = valid_out && ready_in;
  end

  // One schoolbook step per cycle: acc[i+j] += lo(a_j*b_i) + hi(a_{j-1}*b_i)
  // plus the two 1-bit carries. The high half of the previous partial product
  // is kept in hi_q, so only one multiplier is needed. Column j = K is the
  // implicit zero block that flushes hi and the carries into acc[i+K].
  // Read and write of acc happen in the same cycle, so no hazard exists.
  always_comb begin
    a_j      = (j_q == K_C) ? '0 : a_mem_q[j_q[AW-1:0]];
    b_i      = b_mem_q[i_q[AW-1:0]];
    hi_in    = (j_q == '0) ? '0 : hi_q;
    cp_in    = (j_q == '0) ? 1'b0 : cp_q;
    ca_in    = (j_q == '0) ? 1'b0 : ca_q;
    p_cur    = {{W{1'b0}}, a_j} * {{W{1'b0}}, b_i};
    acc_idx  = RW'(i_q + j_q);
    acc_rd   = acc_q[acc_idx];
    s1       = {1'b0, p_cur[W-1:0]} + {1'b0, hi_in} + {{W{1'b0}}, cp_in};
    s2       = {1'b0, acc_rd} + {1'b0, s1[W-1:0]} + {{W{1'b0}}, ca_in};
    j_last   = mode_q ? (j_q == (LASTK_C - i_q)) : (j_q == K_C);
    row_last = (i_q == LASTK_C);
  end

  // Next-state logic. idx_q is shared: clear address in CLEAR, beat index in
  // IDLE/LOAD and output block index in OUTPUT.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    i_d     = i_q;
    j_d     = j_q;
    cp_d    = cp_q;
    ca_d    = ca_q;
    hi_d    = hi_q;
    mode_d  = mode_q;
    case (state_q)
      S_CLEAR: begin
        if (idx_q == LAST2K_C) begin
          state_d = S_IDLE;
          idx_d   = '0;
        end else begin
          idx_d = idx_q + CW'(1);
        end
      end
      S_IDLE, S_LOAD: begin
        if (accept) begin
          if (state_q == S_IDLE) begin
            mode_d = mode_in;
          end
          if (idx_q == LASTK_C) begin
            state_d = S_COMPUTE;
            idx_d   = '0;
            i_d     = '0;
            j_d     = '0;
          end else begin
            state_d = S_LOAD;
            idx_d   = idx_q + CW'(1);
          end
        end
      end
      S_COMPUTE: begin
        cp_d = s1[W];
        ca_d = s2[W];
        hi_d = p_cur[2*W-1:W];
        if (j_last) begin
          j_d = '0;
          if (row_last) begin
            state_d = S_OUTPUT;
            idx_d   = '0;
          end else begin
            i_d = i_q + CW'(1);
          end
        end else begin
          j_d = j_q + CW'(1);
        end
      end
      S_OUTPUT: begin
        if (xfer) begin
          if (last_out) begin
            state_d = S_IDLE;
            idx_d   = '0;
          end else begin
            idx_d = idx_q + CW'(1);
          end
        end
      end
      default: state_d = S_CLEAR;
    endcase
  end

  // Control registers. Reset lands in CLEAR so the accumulator is wiped
  // before any new operation can be accepted.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state_q <= S_CLEAR;
      idx_q   <= '0;
      i_q     <= '0;
      j_q     <= '0;
      cp_q    <= 1'b0;
      ca_q    <= 1'b0;
      hi_q    <= '0;
      mode_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      i_q     <= i_d;
      j_q     <= j_d;
      cp_q    <= cp_d;
      ca_q    <= ca_d;
      hi_q    <= hi_d;
      mode_q  <= mode_d;
    end
  end

  // Operand storage; only accepted beats are written.
  always_ff @(posedge clk_in) begin
    if (accept) begin
      a_mem_q[idx_q[AW-1:0]] <= a_in;
      b_mem_q[idx_q[AW-1:0]] <= b_in;
    end
  end

  // Single accumulator write port: zero fill in CLEAR, step result in
  // COMPUTE, and zero-on-transfer in OUTPUT.
  always_comb begin
    acc_we = 1'b0;
    acc_wa = idx_q[RW-1:0];
    acc_wd = '0;
    case (state_q)
      S_CLEAR:   acc_we = 1'b1;
      S_COMPUTE: begin
        acc_we = 1'b1;
        acc_wa = acc_idx;
        acc_wd = s2[W-1:0];
      end
      S_OUTPUT:  acc_we = xfer;
      default:   acc_we = 1'b0;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (acc_we) begin
      acc_q[acc_wa] <= acc_wd;
    end
  end

endmodule

// File: tb/tb_mp_stream_multiplier.sv
// tb_mp_stream_multiplier
//
// Directed bench for mp_stream_multiplier with W=8, N=32 (K=4). Expected
// result blocks come from a 64-bit integer product and go into a queue when
// operands are driven; they are popped as the DUT transfers blocks.
`timescale 1ns/1ps
module tb_mp_stream_multiplier;

  localparam int W = 8;
  localparam int N = 32;
  localparam int K = N / W;

  typedef struct packed {
    logic         last;
    logic [W-1:0] data;
  } blk_t;

  logic         clk = 1'b0;
  logic         rstN;
  logic [W-1:0] aIn;
  logic [W-1:0] bIn;
  logic         validIn;
  logic         modeIn;
  logic         readyOut;
  logic [W-1:0] dataOut;
  logic         validOut;
  logic         lastOut;
  logic         readyIn;

  blk_t expQ[$];
  int   checks = 0;
  int   errors = 0;

  mp_stream_multiplier #(
    .REGISTER_SIZE(W),
    .BITS_IN_NUM  (N)
  ) dut (
    .clk_in   (clk),
    .rst_in   (rstN),
    .a_in     (aIn),
    .b_in     (bIn),
    .valid_in (validIn),
    .mode_in  (modeIn),
    .ready_out(readyOut),
    .data_out (dataOut),
    .valid_out(validOut),
    .last_out (lastOut),
    .ready_in (readyIn)
  );

  always #5 clk = ~clk;

  // Single comparison point: counts, asserts, reports on mismatch.
  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Push expected blocks, then offer K beats (optionally 1-in-3 duty).
  // Later beats carry an inverted mode_in, which the DUT must ignore.
  task automatic applyStimulus(input logic [N-1:0] a, input logic [N-1:0] b,
                               input logic mode, input bit gaps);
    logic [2*N-1:0] prod;
    blk_t           e;
    int             nBlk;
    int             beat;
    int             cyc;
    prod = {{N{1'b0}}, a} * {{N{1'b0}}, b};
    nBlk = mode ? K : 2*K;
    for (int k = 0; k < nBlk; k++) begin
      e.last = (k == nBlk - 1);
      e.data = prod[k*W +: W];
      expQ.push_back(e);
    end
    beat = 0;
    cyc  = 0;
    while (beat < K && cyc < 100) begin
      @(negedge clk);
      cyc++;
      if (gaps && (cyc % 3 != 1)) begin
        validIn = 1'b0;
        aIn     = W'($urandom);
        bIn     = W'($urandom);
        modeIn  = 1'($urandom);
      end else begin
        validIn = 1'b1;
        aIn     = a[beat*W +: W];
        bIn     = b[beat*W +: W];
        modeIn  = (beat == 0) ? mode : ~mode;
        if (readyOut) beat++;
      end
    end
    checkOutput("load_beats", 64'(beat), 64'(K));
    @(negedge clk);
    validIn = 1'b0;
  endtask

  // Collect nBlk blocks against the scoreboard with optional random
  // backpressure and optional junk beats offered while busy.
  task automatic drainOutput(input int nBlk, input bit bp, input bit garbage, input int bound);
    blk_t         e;
    int           got;
    int           cyc;
    bit           seenFirst;
    bit           stalled;
    logic [W-1:0] held;
    logic         heldLast;
    got       = 0;
    cyc       = 0;
    seenFirst = 1'b0;
    stalled   = 1'b0;
    held      = '0;
    heldLast  = 1'b0;
    while (got < nBlk && cyc < 400) begin
      @(negedge clk);
      cyc++;
      readyIn = bp ? 1'($urandom_range(0, 1)) : 1'b1;
      if (garbage) begin
        validIn = 1'b1;
        aIn     = W'($urandom);
        bIn     = W'($urandom);
        modeIn  = 1'($urandom);
      end
      if (stalled) begin
        checkOutput("stall_valid", 64'(validOut), 64'(1));
        checkOutput("stall_data", 64'(dataOut), 64'(held));
        checkOutput("stall_last", 64'(lastOut), 64'(heldLast));
      end
      stalled = 1'b0;
      if (validOut) begin
        if (!seenFirst) begin
          seenFirst = 1'b1;
          checkOutput("latency", 64'(cyc <= bound), 64'(1));
        end
        if (garbage) checkOutput("ready_low_busy", 64'(readyOut), 64'(0));
        if (readyIn) begin
          checkOutput("queue_nonempty", 64'(expQ.size() > 0), 64'(1));
          if (expQ.size() > 0) begin
            e = expQ.pop_front();
            checkOutput("data", 64'(dataOut), 64'(e.data));
            checkOutput("last", 64'(lastOut), 64'(e.last));
          end
          got++;
        end else begin
          stalled  = 1'b1;
          held     = dataOut;
          heldLast = lastOut;
        end
      end
    end
    checkOutput("block_count", 64'(got), 64'(nBlk));
    @(negedge clk);
    validIn = 1'b0;
    readyIn = 1'b1;
    checkOutput("ready_after_op", 64'(readyOut), 64'(1));
  endtask

  // Release reset on a falling edge and count cycles until ready_out rises.
  task automatic releaseReset();
    int c;
    @(negedge clk);
    rstN = 1'b1;
    c = 0;
    while (!readyOut && c < 50) begin
      @(negedge clk);
      c++;
    end
    checkOutput("clear_length", 64'(c), 64'(2*K));
  endtask

  initial begin
    rstN    = 1'b0;
    aIn     = '0;
    bIn     = '0;
    validIn = 1'b0;
    modeIn  = 1'b0;
    readyIn = 1'b1;
    #1;
    checkOutput("rst_data", 64'(dataOut), 64'(0));
    checkOutput("rst_valid", 64'(validOut), 64'(0));
    checkOutput("rst_last", 64'(lastOut), 64'(0));
    checkOutput("rst_ready", 64'(readyOut), 64'(0));
    repeat (2) @(negedge clk);
    releaseReset();

    $display("[TB] full mode, all-ones operands");
    applyStimulus(32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 1'b0);
    drainOutput(2*K, 1'b0, 1'b0, K*(K+1) + 8);

    $display("[TB] low-half mode, all-ones operands");
    applyStimulus(32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 1'b0);
    drainOutput(K, 1'b0, 1'b0, K*(K+3)/2 + 8);

    $display("[TB] full mode with random backpressure");
    applyStimulus(32'h12345678, 32'h9ABCDEF0, 1'b0, 1'b0);
    drainOutput(2*K, 1'b1, 1'b0, K*(K+1) + 8);

    $display("[TB] back-to-back operations");
    applyStimulus(32'h00000000, 32'hDEADBEEF, 1'b0, 1'b0);
    drainOutput(2*K, 1'b0, 1'b0, K*(K+1) + 8);
    applyStimulus(32'h00000002, 32'h00000003, 1'b0, 1'b0);
    drainOutput(2*K, 1'b0, 1'b0, K*(K+1) + 8);

    $display("[TB] reset during compute");
    applyStimulus(32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 1'b0);
    repeat (5) @(negedge clk);
    #2;
    rstN = 1'b0;
    #1;
    checkOutput("midrst_valid", 64'(validOut), 64'(0));
    checkOutput("midrst_ready", 64'(readyOut), 64'(0));
    checkOutput("midrst_data", 64'(dataOut), 64'(0));
    checkOutput("midrst_last", 64'(lastOut), 64'(0));
    expQ.delete();
    releaseReset();
    applyStimulus(32'h00010000, 32'h00010000, 1'b0, 1'b0);
    drainOutput(2*K, 1'b0, 1'b0, K*(K+1) + 8);

    $display("[TB] gapped load with junk beats while busy");
    applyStimulus(32'h12345678, 32'h9ABCDEF0, 1'b0, 1'b1);
    drainOutput(2*K, 1'b0, 1'b1, K*(K+1) + 8);
    applyStimulus(32'h89ABCDEF, 32'h01234567, 1'b1, 1'b0);
    drainOutput(K, 1'b1, 1'b0, K*(K+3)/2 + 8);

    checkOutput("scoreboard_empty", 64'(expQ.size()), 64'(0));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
